// File: rtl/calc_pkg.sv
// calc_pkg: key codes, op encoding and FSM state encoding shared by calc_ctrl and calc_alu
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_EQ = 4'd12;
  localparam logic [3:0] KEY_CLR = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_NONE = 4'd15;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [2:0] {S_IDLE, S_WR_ENT, S_EXEC, S_WR_ACC, S_CLR0, S_CLR1} state_t;
endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational accumulator op; multiplier only built when CALC_MUL_EN is defined
module calc_alu
  import calc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  op_t         op,
  output logic [15:0] y,
  output logic        ovf
);
  logic [16:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
`ifdef CALC_MUL_EN
  logic [31:0] prod;
  assign prod = {16'h0, a} * {16'h0, b};
  always_comb begin
    y = op == OP_ADD ? sum[15:0] : op == OP_SUB ? dif[15:0] : op == OP_MUL ? prod[15:0] : b;
    ovf = op == OP_ADD ? sum[16] : op == OP_SUB ? dif[16] : op == OP_MUL ? |prod[31:16] : 1'b0;
  end
`else
  always_comb begin
    y = op == OP_ADD ? sum[15:0] : op == OP_SUB ? dif[15:0] : b;
    ovf = op == OP_ADD ? sum[16] : op == OP_SUB ? dif[16] : 1'b0;
  end
`endif
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: digit entry, op sequencing and regfile write/read control; CALC_MUL_EN enables key 14 '*'
module calc_ctrl
  import calc_pkg::*;
#(
  parameter logic [1:0] ACC_REG = 2'd0,
  parameter logic [1:0] ENT_REG = 2'd1
) (
  input  logic        ck,
  input  logic        res,
  input  logic [3:0]  key,
  input  logic        key_vld,
  output logic        busy,
  input  logic [15:0] rf_q,
  output logic [15:0] rf_d,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  rf_rsel,
  output logic        rf_we,
  output logic [15:0] disp,
  output logic        err
);
`ifdef CALC_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif
  state_t state, nxt;
  logic [15:0] entry, res_r, alu_y;
  logic [19:0] ent_x10;
  logic acc, is_dig, is_op, alu_ovf;
  op_t pend_op, new_op, key_op;
  assign acc = key_vld && state == S_IDLE;
  assign is_dig = key < 4'd10;
  assign is_op = key == KEY_ADD || key == KEY_SUB || key == KEY_EQ || (MUL_EN && key == KEY_MUL);
  assign key_op = key == KEY_ADD ? OP_ADD : key == KEY_SUB ? OP_SUB : key == KEY_MUL ? OP_MUL : OP_NONE;
  assign ent_x10 = {4'h0, entry} * 20'd10 + {16'h0, key};
  calc_alu u_alu (.a(rf_q), .b(entry), .op(pend_op), .y(alu_y), .ovf(alu_ovf));
  always_ff @(posedge ck or negedge res)
    if (!res) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == S_IDLE ? (acc && is_op ? S_WR_ENT : acc && key == KEY_CLR ? S_CLR0 : S_IDLE) :
          state == S_WR_ENT ? S_EXEC :
          state == S_EXEC ? S_WR_ACC :
          state == S_CLR0 ? S_CLR1 : S_IDLE;
  always_comb begin
    busy = state != S_IDLE;
    rf_we = !(state inside {S_WR_ENT, S_WR_ACC, S_CLR0, S_CLR1});
    rf_wsel = state inside {S_WR_ENT, S_CLR1} ? ENT_REG : state inside {S_WR_ACC, S_CLR0} ? ACC_REG : 2'd0;
    rf_d = state == S_WR_ENT ? entry : state == S_WR_ACC ? res_r : 16'h0;
    rf_rsel = ACC_REG;
  end
  always_ff @(posedge ck or negedge res)
    if (!res) begin
      entry <= '0;
      disp <= '0;
      err <= 1'b0;
      res_r <= '0;
      pend_op <= OP_NONE;
      new_op <= OP_NONE;
    end else begin
      // an overflowing digit leaves entry intact and only flags the error
      if (acc && is_dig) begin
        if (|ent_x10[19:16]) err <= 1'b1;
        else begin
          entry <= ent_x10[15:0];
          disp <= ent_x10[15:0];
        end
      end
      if (acc && is_op) new_op <= key_op;
      if (state == S_EXEC) begin
        res_r <= alu_y;
        if (alu_ovf) err <= 1'b1;
      end
      if (state == S_WR_ACC) begin
        disp <= res_r;
        entry <= '0;
        pend_op <= new_op;
      end
      if (state == S_CLR0) begin
        entry <= '0;
        disp <= '0;
        err <= 1'b0;
        pend_op <= OP_NONE;
      end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: calc_ctrl with a behavioural 4x16 regfile, scoreboard checked on sequence end or probe
module tb_calc_ctrl;
  typedef struct {
    logic [15:0] disp;
    logic        err;
    logic [15:0] r0;
    logic [15:0] r1;
    int          writes;
  } exp_t;
  logic ck = 1'b0, res = 1'b0, key_vld = 1'b0, chk = 1'b0, prev_busy = 1'b0;
  logic [3:0] key = 4'd15;
  logic busy, rf_we, err;
  logic [15:0] rf_q, rf_d, disp;
  logic [1:0] rf_wsel, rf_rsel;
  logic [15:0] rf [4] = '{default: 16'h0};
  exp_t q[$];
  int passed = 0, total = 0, wr_cnt = 0, npop = 0;
  calc_ctrl dut (.ck(ck), .res(res), .key(key), .key_vld(key_vld), .busy(busy), .rf_q(rf_q),
                 .rf_d(rf_d), .rf_wsel(rf_wsel), .rf_rsel(rf_rsel), .rf_we(rf_we), .disp(disp), .err(err));
  always #5 ck = ~ck;
  assign rf_q = rf[rf_rsel];
  always @(posedge ck) if (!rf_we) rf[rf_wsel] <= rf_d;
  function automatic exp_t mk(logic [15:0] d, logic e, logic [15:0] a, logic [15:0] b, int w);
    exp_t x;
    x.disp = d; x.err = e; x.r0 = a; x.r1 = b; x.writes = w;
    return x;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  // pop on every completed sequence (busy falling) or on an explicit probe pulse
  always @(negedge ck) begin
    exp_t e;
    if (!rf_we) wr_cnt++;
    if ((prev_busy && !busy) || chk) begin
      npop++;
      if (q.size() == 0) check($sformatf("sb_empty#%0d", npop), 1, 0);
      else begin
        e = q.pop_front();
        check($sformatf("disp#%0d", npop), disp, e.disp);
        check($sformatf("err#%0d", npop), err, e.err);
        check($sformatf("r0#%0d", npop), rf[0], e.r0);
        check($sformatf("r1#%0d", npop), rf[1], e.r1);
        check($sformatf("writes#%0d", npop), wr_cnt, e.writes);
      end
      wr_cnt = 0;
    end
    prev_busy = busy;
  end
  task automatic press(input logic [3:0] k, input bit noisy = 1'b0);
    @(posedge ck); #1;
    key = k; key_vld = 1'b1;
    @(posedge ck); #1;
    key_vld = 1'b0; key = 4'd15;
    if (noisy && busy) begin
      key = 4'd9; key_vld = 1'b1;
      repeat (3) @(posedge ck);
      #1;
      key_vld = 1'b0; key = 4'd15;
    end
    for (int i = 0; i < 8 && busy; i++) begin
      @(posedge ck); #1;
    end
    if (busy) check("busy_timeout", busy, 0);
  endtask
  task automatic probe(input exp_t e);
    q.push_back(e);
    @(posedge ck); #1;
    chk = 1'b1;
    @(posedge ck); #1;
    chk = 1'b0;
  endtask
  task automatic reset_vals(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rf_we"}, rf_we, 1);
    check({tag, "_rf_d"}, rf_d, 0);
    check({tag, "_rf_wsel"}, rf_wsel, 0);
    check({tag, "_rf_rsel"}, rf_rsel, 0);
    check({tag, "_disp"}, disp, 0);
    check({tag, "_err"}, err, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 reset_vals("rst");
    repeat (2) @(posedge ck);
    #1 res = 1'b1;
    // 12 + 3
    press(1); press(2);
    q.push_back(mk(16'd12, 0, 16'd12, 16'd12, 2)); press(10);
    press(3);
    q.push_back(mk(16'd15, 0, 16'd15, 16'd3, 2)); press(12);
    // 5 - 7 borrows, then clear
    q.push_back(mk(0, 0, 0, 0, 2)); press(13);
    press(5);
    q.push_back(mk(16'd5, 0, 16'd5, 16'd5, 2)); press(11);
    press(7);
    q.push_back(mk(16'hFFFE, 1, 16'hFFFE, 16'd7, 2)); press(12);
    q.push_back(mk(0, 0, 0, 0, 2)); press(13);
    // entry saturation boundary
    press(6); press(5); press(5); press(3); press(5);
    probe(mk(16'hFFFF, 0, 0, 0, 0));
    press(0);
    probe(mk(16'hFFFF, 1, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 2)); press(13);
    // keys strobed while busy are dropped
    press(4);
    q.push_back(mk(16'd4, 0, 16'd4, 16'd4, 2)); press(10, 1'b1);
    press(2);
    q.push_back(mk(16'd6, 0, 16'd6, 16'd2, 2)); press(12, 1'b1);
    press(1);
    probe(mk(16'd1, 0, 16'd6, 16'd2, 0));
    // reset in EXEC: WR_ENT happened, WR_ACC must not
    q.push_back(mk(0, 0, 16'd6, 16'd1, 1));
    @(posedge ck); #1;
    key = 4'd10; key_vld = 1'b1;
    @(posedge ck); #1;
    key_vld = 1'b0; key = 4'd15;
    @(posedge ck); #1;
    res = 1'b0;
    #1 reset_vals("mid");
    repeat (2) @(posedge ck);
    #1 res = 1'b1;
    press(7);
    probe(mk(16'd7, 0, 16'd6, 16'd1, 0));
    q.push_back(mk(0, 0, 0, 0, 2)); press(13);
    press(3); press(0); press(0);
`ifdef CALC_MUL_EN
    q.push_back(mk(16'd300, 0, 16'd300, 16'd300, 2)); press(14);
    press(3); press(0); press(0);
    q.push_back(mk(16'h5F90, 1, 16'h5F90, 16'd300, 2)); press(12);
    press(15);
    probe(mk(16'h5F90, 1, 16'h5F90, 16'd300, 0));
`else
    press(14); press(15);
    probe(mk(16'd300, 0, 0, 0, 0));
    press(5);
    probe(mk(16'd3005, 0, 0, 0, 0));
`endif
    repeat (4) @(posedge ck);
    #1 check("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
